// File: rtl/writeback_commit_unit.sv
// Writeback stage: forms the final rd value (ALU / load / link), buffers
// completed instructions in an in-order commit queue feeding the register-file
// write port, and offers youngest-first forwarding over pending writes.
module writeback_commit_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_wb_sel,
  input  logic                     in_write_en,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_alu_result,
  input  logic [XLEN-1:0]          in_link_addr,
  input  logic [XLEN-1:0]          in_load_data,
  input  logic [2:0]               in_funct3,
  input  logic [1:0]               in_addr_lo,
  input  logic                     rf_ready,
  output logic                     rf_write_en,
  output logic [4:0]               rf_rd_addr,
  output logic [XLEN-1:0]          rf_rd_data,
  input  logic [4:0]               lookup_addr,
  output logic                     lookup_hit,
  output logic [XLEN-1:0]          lookup_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         retire_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [OW-1:0]  count;

  entry_t         new_entry;
  entry_t         head;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_word;
  logic [XLEN-1:0] load_val;
  logic           empty;
  logic           enq;
  logic           deq;

  assign empty    = (count == '0);
  assign in_ready = (count < OW'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign deq      = !empty && (rf_ready || !head.we);

  // Load extraction: pick the addressed byte/half and extend per funct3
  always_comb begin
    ld_word = in_load_data[31:0];
    ld_half = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];
    case (in_addr_lo)
      2'd0:    ld_byte = in_load_data[7:0];
      2'd1:    ld_byte = in_load_data[15:8];
      2'd2:    ld_byte = in_load_data[23:16];
      default: ld_byte = in_load_data[31:24];
    endcase
    case (in_funct3)
      3'b000:  load_val = XLEN'($signed(ld_byte));
      3'b100:  load_val = XLEN'(ld_byte);
      3'b001:  load_val = XLEN'($signed(ld_half));
      3'b101:  load_val = XLEN'(ld_half);
      3'b110:  load_val = (XLEN == 64) ? XLEN'(ld_word) : XLEN'($signed(ld_word));
      3'b011:  load_val = (XLEN == 64) ? in_load_data : XLEN'($signed(ld_word));
      default: load_val = XLEN'($signed(ld_word));
    endcase
  end

  // Writeback value selection and effective write enable for the new entry
  always_comb begin
    new_entry.rd = in_rd;
    new_entry.we = in_write_en && (in_rd != 5'd0) && (in_wb_sel != 2'd3);
    case (in_wb_sel)
      SEL_ALU:  new_entry.data = in_alu_result;
      SEL_LOAD: new_entry.data = load_val;
      SEL_LINK: new_entry.data = in_link_addr;
      default:  new_entry.data = '0;
    endcase
  end

  // Queue storage; contents are only meaningful under the occupancy count
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= new_entry;
  end

  // Queue pointers, occupancy and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      retire_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) begin
        rd_ptr       <= rd_ptr + AW'(1);
        retire_count <= retire_count + CNT_W'(1);
      end
      if (enq && !deq)      count <= count + OW'(1);
      else if (!enq && deq) count <= count - OW'(1);
    end
  end

  assign occupancy = count;

  // Head presentation to the register-file port; data zeroed unless writing
  always_comb begin
    rf_write_en = 1'b0;
    rf_rd_addr  = 5'd0;
    rf_rd_data  = '0;
    if (!empty) begin
      rf_write_en = head.we;
      rf_rd_addr  = head.rd;
      if (head.we) rf_rd_data = head.data;
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [AW-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((OW'(i) < count) && mem[idx].we && (mem[idx].rd == lookup_addr) &&
          (lookup_addr != 5'd0)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Directed bench for writeback_commit_unit with a scoreboard of expected
// register-file writes checked by an independent monitor.
module tb_writeback_commit_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_wb_sel;
  logic             in_write_en;
  logic [4:0]       in_rd;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_link_addr;
  logic [XLEN-1:0]  in_load_data;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic             rf_ready;
  logic             rf_write_en;
  logic [4:0]       rf_rd_addr;
  logic [XLEN-1:0]  rf_rd_data;
  logic [4:0]       lookup_addr;
  logic             lookup_hit;
  logic [XLEN-1:0]  lookup_data;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] retire_count;

  writeback_commit_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_write_en(in_write_en), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_link_addr(in_link_addr),
    .in_load_data(in_load_data), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .rf_ready(rf_ready), .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .occupancy(occupancy), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t         sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_retire  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted register-file write must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rf_write_en && rf_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected none", rf_rd_addr, rf_rd_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wb_rd", 64'(rf_rd_addr), 64'(e.rd));
        check("wb_data", 64'(rf_rd_data), 64'(e.data));
      end
    end
  end

  // Offer one instruction, waiting (bounded) for in_ready; exp_data is hand-computed
  task automatic enq(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] link, input logic [31:0] ld,
                     input logic [2:0] f3, input logic [1:0] lo,
                     input logic writes, input logic [31:0] exp_data);
    int budget;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    in_valid = 1'b1; in_wb_sel = sel; in_write_en = we; in_rd = rd;
    in_alu_result = alu; in_link_addr = link; in_load_data = ld;
    in_funct3 = f3; in_addr_lo = lo;
    if (writes) sb.push_back({rd, exp_data});
    exp_retire++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] LW_WORD = 32'h80F0_7F01;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wb_sel = 2'd0; in_write_en = 1'b0; in_rd = 5'd0;
    in_alu_result = '0; in_link_addr = '0; in_load_data = '0; in_funct3 = 3'd0;
    in_addr_lo = 2'd0; rf_ready = 1'b0; lookup_addr = 5'd0;
    cycles(2);
    rst = 1'b0;
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_write_en", 64'(rf_write_en), 64'd0);
    check("rst_rf_rd_addr", 64'(rf_rd_addr), 64'd0);
    check("rst_rf_rd_data", 64'(rf_rd_data), 64'd0);
    check("rst_retire", retire_count, 64'd0);
    check("rst_lookup_hit", 64'(lookup_hit), 64'd0);

    // ALU write: visible the cycle after enqueue, retired one edge later
    rf_ready = 1'b1;
    enq(2'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, 0, 3'd0, 2'd0, 1'b1, 32'hDEAD_BEEF);
    check("alu_we_visible", 64'(rf_write_en), 64'd1);
    check("alu_occ_before", 64'(occupancy), 64'd1);
    cycles(1);
    check("alu_retire", retire_count, 64'd1);
    check("alu_occ_after", 64'(occupancy), 64'd0);

    // Load extraction table plus a link write
    enq(2'd1, 1'b1, 5'd1, 0, 0, LW_WORD, 3'b000, 2'd2, 1'b1, 32'hFFFF_FFF0);
    enq(2'd1, 1'b1, 5'd2, 0, 0, LW_WORD, 3'b100, 2'd2, 1'b1, 32'h0000_00F0);
    enq(2'd1, 1'b1, 5'd3, 0, 0, LW_WORD, 3'b001, 2'd2, 1'b1, 32'hFFFF_80F0);
    enq(2'd1, 1'b1, 5'd4, 0, 0, LW_WORD, 3'b101, 2'd2, 1'b1, 32'h0000_80F0);
    enq(2'd1, 1'b1, 5'd6, 0, 0, LW_WORD, 3'b000, 2'd0, 1'b1, 32'h0000_0001);
    enq(2'd1, 1'b1, 5'd7, 0, 0, LW_WORD, 3'b001, 2'd3, 1'b1, 32'hFFFF_80F0);
    enq(2'd1, 1'b1, 5'd8, 0, 0, LW_WORD, 3'b010, 2'd0, 1'b1, 32'h80F0_7F01);
    enq(2'd1, 1'b1, 5'd9, 0, 0, LW_WORD, 3'b000, 2'd1, 1'b1, 32'h0000_007F);
    enq(2'd2, 1'b1, 5'd1, 32'h5555_5555, 32'h0000_1004, 0, 3'd0, 2'd0, 1'b1, 32'h0000_1004);
    cycles(2);
    check("loads_drained", 64'(occupancy), 64'd0);

    // Back-pressure: queue fills to DEPTH then drains in order
    rf_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      enq(2'd0, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 0, 0, 3'd0, 2'd0, 1'b1, 32'h100 + 32'(i));
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    cycles(2);
    check("stall_occupancy", 64'(occupancy), 64'(DEPTH));
    rf_ready = 1'b1;
    enq(2'd0, 1'b1, 5'd20, 32'h200, 0, 0, 3'd0, 2'd0, 1'b1, 32'h200);
    cycles(4);
    check("drain_occupancy", 64'(occupancy), 64'd0);
    check("drain_retire", retire_count, exp_retire);

    // Non-writing entries retire without rf_ready
    rf_ready = 1'b0;
    enq(2'd0, 1'b1, 5'd0, 32'hABCD, 0, 0, 3'd0, 2'd0, 1'b0, 0);
    check("rd0_no_we", 64'(rf_write_en), 64'd0);
    enq(2'd3, 1'b1, 5'd7, 32'hABCD, 0, 0, 3'd0, 2'd0, 1'b0, 0);
    check("none_no_we", 64'(rf_write_en), 64'd0);
    cycles(1);
    check("nowrite_occupancy", 64'(occupancy), 64'd0);
    check("nowrite_retire", retire_count, exp_retire);

    // Forwarding: youngest of two rd=3 entries wins; rd=0 never hits
    enq(2'd0, 1'b1, 5'd3, 32'h11, 0, 0, 3'd0, 2'd0, 1'b1, 32'h11);
    enq(2'd0, 1'b1, 5'd3, 32'h22, 0, 0, 3'd0, 2'd0, 1'b1, 32'h22);
    lookup_addr = 5'd3; #1;
    check("fwd_hit", 64'(lookup_hit), 64'd1);
    check("fwd_data", 64'(lookup_data), 64'h22);
    lookup_addr = 5'd0; #1;
    check("fwd_x0_hit", 64'(lookup_hit), 64'd0);
    lookup_addr = 5'd4; #1;
    check("fwd_miss_hit", 64'(lookup_hit), 64'd0);
    check("fwd_miss_data", 64'(lookup_data), 64'd0);

    // Reset with three entries queued discards them uncounted
    enq(2'd0, 1'b1, 5'd9, 32'h33, 0, 0, 3'd0, 2'd0, 1'b1, 32'h33);
    check("pre_rst_occupancy", 64'(occupancy), 64'd3);
    rst = 1'b1;
    cycles(1);
    sb.delete();
    exp_retire = 0;
    rst = 1'b0;
    check("midrst_occupancy", 64'(occupancy), 64'd0);
    check("midrst_we", 64'(rf_write_en), 64'd0);
    check("midrst_retire", retire_count, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    rf_ready = 1'b1;
    lookup_addr = 5'd3;
    cycles(3);
    check("post_rst_lookup", 64'(lookup_hit), 64'd0);
    check("post_rst_retire", retire_count, 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
